// File: rtl/ascon_blk_packer.sv
// ascon_blk_packer
// Upstream feeder for the ASCON core. Takes a 32-bit word stream of AD
// followed by PT, packs it into 64-bit blocks, applies ASCON padding
// (0x01 after the last data byte, zeros above) and hands blocks to the
// core through its request/valid handshake.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   start_i                 start pulse (accepted only when idle)
//   ad_len_i, pt_len_i      byte lengths, sampled on an accepted start
//   word_i/word_valid_i     input word stream, byte k at [8k+7:8k]
//   word_ready_o            word consumed when valid && ready
//   blk_req_i               core block request (core data_req_o)
//   blk_valid_o, blk_o      block handoff (core data_valid_i / data_i)
//   ad_blocks_o/pt_blocks_o block counts to the core
//   core_start_o            one-cycle start pulse to the core
//   busy_o                  high outside IDLE
//   done_o                  pulse after the last PT block is handed off
//   err_o                   pulse after a rejected start (count overflow)
//
// Build option:
//   ASCON_PACKER_BSWAP_EN   byte-reverse every accepted word (big-endian
//                           hosts); masking/padding apply after the swap.
module ascon_blk_packer #(
  parameter int AD_LEN_W  = 13,
  parameter int PT_LEN_W  = 13,
  parameter int BLK_AD_AW = 10,
  parameter int BLK_PT_AW = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [AD_LEN_W-1:0]  ad_len_i,
  input  logic [PT_LEN_W-1:0]  pt_len_i,
  input  logic [31:0]          word_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic                 blk_req_i,
  output logic                 blk_valid_o,
  output logic [63:0]          blk_o,
  output logic [BLK_AD_AW-1:0] ad_blocks_o,
  output logic [BLK_PT_AW-1:0] pt_blocks_o,
  output logic                 core_start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int LW    = (AD_LEN_W > PT_LEN_W) ? AD_LEN_W : PT_LEN_W;
  localparam int CW    = (BLK_AD_AW > BLK_PT_AW) ? BLK_AD_AW : BLK_PT_AW;
  localparam int AD_CW = AD_LEN_W + 1;
  localparam int PT_CW = PT_LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_AD_FILL, S_AD_HOLD, S_PT_FILL, S_PT_HOLD, S_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [PT_LEN_W-1:0]  pt_len_q;
  logic [BLK_AD_AW-1:0] ad_blocks_q;
  logic [BLK_PT_AW-1:0] pt_blocks_q;
  logic [LW-1:0]        rem_q;      // bytes left in the current section
  logic [CW-1:0]        cnt_q;      // blocks left in the current section
  logic                 widx_q;     // next word slot inside the block
  logic [63:0]          blk_q, blk_d;
  logic                 pend_q, pend_d;
  logic                 err_q;

  // ---------------------------------------------------------------------
  // Start qualification
  // ---------------------------------------------------------------------
  logic [AD_CW-1:0] ad_cnt;
  logic [PT_CW-1:0] pt_cnt;
  logic             ovf, start_ok, start_bad;

  always_comb begin
    ad_cnt    = AD_CW'(ad_len_i >> 3) + AD_CW'(1);
    pt_cnt    = PT_CW'(pt_len_i >> 3) + PT_CW'(1);
    // a count is too large iff any bit at or above the core's width is set
    ovf       = ((ad_cnt >> BLK_AD_AW) != '0) || ((pt_cnt >> BLK_PT_AW) != '0);
    start_ok  = start_i && (state_q == S_IDLE) && !ovf;
    start_bad = start_i && (state_q == S_IDLE) && ovf;
  end

  // ---------------------------------------------------------------------
  // Block fill bookkeeping
  // ---------------------------------------------------------------------
  logic        in_fill, in_hold;
  logic [3:0]  rb;        // bytes of data in this block, capped at 8
  logic [1:0]  nwords;
  logic        word_hs, last_word, fill_done, handoff, last_blk;

  always_comb begin
    in_fill   = (state_q == S_AD_FILL) || (state_q == S_PT_FILL);
    in_hold   = (state_q == S_AD_HOLD) || (state_q == S_PT_HOLD);
    rb        = (rem_q >= LW'(8)) ? 4'd8 : rem_q[3:0];
    nwords    = rb[3] ? 2'd2 : 2'((rb + 4'd3) >> 2);
    word_hs   = in_fill && (nwords != 2'd0) && word_valid_i;
    last_word = word_hs && ({1'b0, widx_q} == (nwords - 2'd1));
    fill_done = in_fill && ((nwords == 2'd0) || last_word);
    handoff   = in_hold && (blk_req_i || pend_q);
    last_blk  = (cnt_q == CW'(1));
  end

  // ---------------------------------------------------------------------
  // Datapath: byte swap, masking, padding
  // ---------------------------------------------------------------------
  logic [31:0] wsw, lane;
  logic [2:0]  bpos;

  always_comb begin
`ifdef ASCON_PACKER_BSWAP_EN
    wsw = {word_i[7:0], word_i[15:8], word_i[23:16], word_i[31:24]};
`else
    wsw = word_i;
`endif
    lane = '0;
    bpos = '0;
    for (int k = 0; k < 4; k++) begin
      bpos = {widx_q, 2'(k)};
      // drop bytes past the message end, whatever the host sent there
      if ({1'b0, bpos} < rb) lane[8*k +: 8] = wsw[8*k +: 8];
    end

    blk_d = blk_q;
    if (start_ok || handoff) begin
      blk_d = '0;
    end else if (in_fill) begin
      if (word_hs) begin
        if (widx_q) blk_d[63:32] = lane;
        else        blk_d[31:0]  = lane;
      end
      // short block: pad byte goes right after the last data byte
      if (fill_done && !rb[3]) blk_d[{rb[2:0], 3'b000} +: 8] = 8'h01;
    end
  end

  // One request is remembered while the block is not ready yet; further
  // requests before the handoff collapse into it.
  always_comb begin
    pend_d = pend_q;
    if (handoff)
      pend_d = 1'b0;
    else if (((state_q == S_LAUNCH) || in_fill) && blk_req_i)
      pend_d = 1'b1;
    else if ((state_q == S_IDLE) || (state_q == S_FINISH))
      pend_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pt_len_q    <= '0;
      ad_blocks_q <= '0;
      pt_blocks_q <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      widx_q      <= 1'b0;
      blk_q       <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q  <= start_bad;
      pend_q <= pend_d;
      blk_q  <= blk_d;
      if (start_ok) begin
        pt_len_q    <= pt_len_i;
        ad_blocks_q <= BLK_AD_AW'(ad_cnt);
        pt_blocks_q <= BLK_PT_AW'(pt_cnt);
        rem_q       <= LW'(ad_len_i);
        cnt_q       <= CW'(ad_cnt);
        widx_q      <= 1'b0;
      end else begin
        if (word_hs) widx_q <= !last_word;
        if (handoff) begin
          if (last_blk && (state_q == S_AD_HOLD)) begin
            rem_q <= LW'(pt_len_q);
            cnt_q <= CW'(pt_blocks_q);
          end else begin
            if (rem_q >= LW'(8)) rem_q <= rem_q - LW'(8);
            cnt_q <= cnt_q - CW'(1);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_LAUNCH;
      S_LAUNCH:  state_d = S_AD_FILL;
      S_AD_FILL: if (fill_done) state_d = S_AD_HOLD;
      S_AD_HOLD: if (handoff) state_d = last_blk ? S_PT_FILL : S_AD_FILL;
      S_PT_FILL: if (fill_done) state_d = S_PT_HOLD;
      S_PT_HOLD: if (handoff) state_d = last_blk ? S_FINISH : S_PT_FILL;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready_o = in_fill && (nwords != 2'd0);
    blk_valid_o  = handoff;
    core_start_o = (state_q == S_LAUNCH);
    done_o       = (state_q == S_FINISH);
    busy_o       = (state_q != S_IDLE);
    err_o        = err_q;
    blk_o        = blk_q;
    ad_blocks_o  = ad_blocks_q;
    pt_blocks_o  = pt_blocks_q;
  end

endmodule
